reservation_station: RTL and testbench

Holds instructions accepted from the two-wide issuer until their source operands are available, snooping the common data bus (CDB) for results. It dispatches the oldest ready entry to its functional unit over a valid/ready handshake. It reports fullness back to the issuer as one bit of `st_fullness`. One instance exists per functional-unit class (ALU, branch, load/store).

---
 rtl/reservation_station_pkg.sv | 57 +++++
 rtl/reservation_station_select.sv | 23 ++
 rtl/reservation_station.sv | 152 +++++++++++++++
 tb/tb_reservation_station.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reservation_station_pkg.sv
// Shared types for the reservation station: operation names, issue payloads,
// dispatch payload, CDB broadcast and the internal per-entry record.
package reservation_station_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned TAG_W = 6;

   typedef enum logic [3:0] {
      I_ADD, I_SUB, I_AND, I_OR, I_XOR, I_SLT, I_BEQ, I_BNE, I_LW, I_SW, I_NOP
   } instr_name_e;

   typedef struct packed {
      logic [TAG_W-1:0] src1;
      logic [TAG_W-1:0] src2;
      logic [TAG_W-1:0] dest;
   } src_dest_t;

   typedef struct packed {
      logic [XLEN-1:0]  address;
      logic [XLEN-1:0]  immediate;
      instr_name_e      instr_name;
      logic [XLEN-1:0]  src1_val;
      logic [XLEN-1:0]  src2_val;
      logic [TAG_W-1:0] dest;
   } rs_entry_t;

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic [XLEN-1:0]  data;
   } cdb_t;

   typedef struct packed {
      logic                  valid;
      logic [XLEN-1:0]       address;
      logic [XLEN-1:0]       immediate;
      instr_name_e           instr_name;
      logic [TAG_W-1:0]      dest;
      logic [1:0][TAG_W-1:0] tag;
      logic [1:0][XLEN-1:0]  val;
      logic [1:0]            rdy;
   } rs_slot_t;

   // Capture a CDB result into any waiting source of a valid slot.
   function automatic rs_slot_t slot_snoop(input rs_slot_t s, input cdb_t cdb);
      rs_slot_t r;
      r = s;
      for (int k = 0; k < 2; k++) begin
         if (r.valid && !r.rdy[k] && cdb.valid && (r.tag[k] == cdb.tag)) begin
            r.rdy[k] = 1'b1;
            r.val[k] = cdb.data;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/reservation_station_select.sv
// Priority picker: index of the lowest-numbered ready entry plus a found flag.
module rs_select #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned IDX_W = $clog2(DEPTH)
) (
   input  logic [DEPTH-1:0] ready,
   output logic [IDX_W-1:0] idx,
   output logic             found
);

   // Scanning downward lets the lowest ready index win.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
         if (ready[i]) begin
            idx   = IDX_W'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/reservation_station.sv
// Collapsing-queue reservation station: two-wide insert, CDB snoop,
// oldest-ready dispatch with compaction, flush and fullness report.
module reservation_station #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned TAG_W = 6
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   flush,
   input  logic                                   in_valid      [2],
   input  logic [XLEN-1:0]                        in_address    [2],
   input  logic [XLEN-1:0]                        in_immediate  [2],
   input  reservation_station_pkg::instr_name_e   in_instr_name [2],
   input  reservation_station_pkg::src_dest_t     in_regs       [2],
   input  logic [XLEN-1:0]                        in_src_val    [2][2],
   input  logic                                   in_src_rdy    [2][2],
   input  logic                                   cdb_valid,
   input  logic [TAG_W-1:0]                       cdb_tag,
   input  logic [XLEN-1:0]                        cdb_data,
   output logic                                   full,
   output logic                                   out_valid,
   input  logic                                   out_ready,
   output reservation_station_pkg::rs_entry_t     out_entry
);

   import reservation_station_pkg::*;

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   rs_slot_t         entries  [DEPTH];
   rs_slot_t         snp      [DEPTH];
   rs_slot_t         upper    [DEPTH];
   rs_slot_t         nxt      [DEPTH];
   rs_slot_t         incoming [2];
   logic             ins_ok   [2];
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] nxt_count;
   logic [DEPTH-1:0] ready;
   logic [IDX_W-1:0] sel;
   logic             found;
   logic             dispatch;
   cdb_t             cdb;
   int               pos0;
   int               pos1;

   assign cdb = '{valid: cdb_valid, tag: cdb_tag, data: cdb_data};

   always_comb begin
      for (int i = 0; i < int'(DEPTH); i++) begin
         ready[i] = entries[i].valid & (&entries[i].rdy);
      end
   end

   rs_select #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_select (
      .ready (ready),
      .idx   (sel),
      .found (found)
   );

   // Dispatch port is driven straight from the registered entries.
   always_comb begin
      out_valid = found & ~flush;
      out_entry = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (IDX_W'(i) == sel) begin
            out_entry.address    = entries[i].address;
            out_entry.immediate  = entries[i].immediate;
            out_entry.instr_name = entries[i].instr_name;
            out_entry.src1_val   = entries[i].val[0];
            out_entry.src2_val   = entries[i].val[1];
            out_entry.dest       = entries[i].dest;
         end
      end
   end

   // Incoming slots pick up a same-cycle CDB result before being stored.
   always_comb begin
      for (int k = 0; k < 2; k++) begin
         incoming[k]            = '0;
         incoming[k].valid      = 1'b1;
         incoming[k].address    = in_address[k];
         incoming[k].immediate  = in_immediate[k];
         incoming[k].instr_name = in_instr_name[k];
         incoming[k].dest       = in_regs[k].dest;
         incoming[k].tag[0]     = in_regs[k].src1;
         incoming[k].tag[1]     = in_regs[k].src2;
         incoming[k].val[0]     = in_src_val[k][0];
         incoming[k].val[1]     = in_src_val[k][1];
         incoming[k].rdy[0]     = in_src_rdy[k][0];
         incoming[k].rdy[1]     = in_src_rdy[k][1];
         incoming[k]            = slot_snoop(incoming[k], cdb);
      end
   end

   // Next state: snoop, close the gap left by a dispatch, then append inserts.
   always_comb begin
      dispatch = out_valid & out_ready;
      for (int i = 0; i < int'(DEPTH); i++) begin
         snp[i] = slot_snoop(entries[i], cdb);
      end
      for (int i = 0; i < int'(DEPTH) - 1; i++) begin
         upper[i] = snp[i + 1];
      end
      upper[DEPTH-1] = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         nxt[i] = (dispatch && (i >= int'(sel))) ? upper[i] : snp[i];
      end

      pos0      = int'(count) - int'(dispatch);
      ins_ok[0] = in_valid[0] && (pos0 < int'(DEPTH));
      pos1      = pos0 + int'(ins_ok[0]);
      ins_ok[1] = in_valid[1] && (pos1 < int'(DEPTH));
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (ins_ok[0] && (i == pos0)) nxt[i] = incoming[0];
         if (ins_ok[1] && (i == pos1)) nxt[i] = incoming[1];
      end
      nxt_count = CNT_W'(pos1 + int'(ins_ok[1]));

      if (flush) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            nxt[i] = '0;
         end
         nxt_count = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         count <= '0;
         full  <= 1'b0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            entries[i] <= '0;
         end
      end else begin
         count <= nxt_count;
         full  <= int'(nxt_count) > (int'(DEPTH) - 2);
         for (int i = 0; i < int'(DEPTH); i++) begin
            entries[i] <= nxt[i];
         end
      end
   end

   // An issuer that ignores full loses the overflowing slot.
   always_ff @(posedge clk) begin
      if (reset && !flush) begin
         a_no_overflow: assert (!(in_valid[0] && !ins_ok[0]) && !(in_valid[1] && !ins_ok[1]));
      end
   end

endmodule

// File: tb/tb_reservation_station.sv
// Randomized and directed bench for reservation_station against a queue model.
module tb_reservation_station;
   import reservation_station_pkg::*;

   localparam int DEPTH = 8;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] imm;
      instr_name_e name;
      logic [5:0]  dest;
      logic [5:0]  t1;
      logic [5:0]  t2;
      logic [31:0] v1;
      logic [31:0] v2;
      logic        r1;
      logic        r2;
   } m_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        in_valid      [2];
   logic [31:0] in_address    [2];
   logic [31:0] in_immediate  [2];
   instr_name_e in_instr_name [2];
   src_dest_t   in_regs       [2];
   logic [31:0] in_src_val    [2][2];
   logic        in_src_rdy    [2][2];
   logic        cdb_valid;
   logic [5:0]  cdb_tag;
   logic [31:0] cdb_data;
   logic        full;
   logic        out_valid;
   logic        out_ready;
   rs_entry_t   out_entry;

   m_t mq[$];
   bit m_full;
   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   reservation_station #(.XLEN(32), .DEPTH(DEPTH), .TAG_W(6)) dut (
      .clk           (clk),
      .reset         (reset),
      .flush         (flush),
      .in_valid      (in_valid),
      .in_address    (in_address),
      .in_immediate  (in_immediate),
      .in_instr_name (in_instr_name),
      .in_regs       (in_regs),
      .in_src_val    (in_src_val),
      .in_src_rdy    (in_src_rdy),
      .cdb_valid     (cdb_valid),
      .cdb_tag       (cdb_tag),
      .cdb_data      (cdb_data),
      .full          (full),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_entry     (out_entry)
   );

   task automatic check_val(input string name, input logic [191:0] act, input logic [191:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic m_t wake(input m_t e);
      m_t r;
      r = e;
      if (cdb_valid && !r.r1 && (r.t1 == cdb_tag)) begin r.r1 = 1'b1; r.v1 = cdb_data; end
      if (cdb_valid && !r.r2 && (r.t2 == cdb_tag)) begin r.r2 = 1'b1; r.v2 = cdb_data; end
      return r;
   endfunction

   function automatic int first_ready();
      int r;
      r = -1;
      for (int i = 0; i < mq.size(); i++) begin
         if (r < 0 && mq[i].r1 && mq[i].r2) r = i;
      end
      return r;
   endfunction

   function automatic rs_entry_t to_entry(input m_t e);
      rs_entry_t r;
      r.address    = e.addr;
      r.immediate  = e.imm;
      r.instr_name = e.name;
      r.src1_val   = e.v1;
      r.src2_val   = e.v2;
      r.dest       = e.dest;
      return r;
   endfunction

   function automatic m_t slot_to_model(input int k);
      m_t e;
      e.addr = in_address[k];
      e.imm  = in_immediate[k];
      e.name = in_instr_name[k];
      e.dest = in_regs[k].dest;
      e.t1   = in_regs[k].src1;
      e.t2   = in_regs[k].src2;
      e.v1   = in_src_val[k][0];
      e.v2   = in_src_val[k][1];
      e.r1   = in_src_rdy[k][0];
      e.r2   = in_src_rdy[k][1];
      return e;
   endfunction

   // Advance the model across one clock edge using the inputs now presented.
   function automatic void model_step();
      int  s;
      bit  disp;
      if (flush) begin
         mq.delete();
         m_full = 1'b0;
         return;
      end
      s    = first_ready();
      disp = (s >= 0) && out_ready;
      for (int i = 0; i < mq.size(); i++) mq[i] = wake(mq[i]);
      if (disp) mq.delete(s);
      for (int k = 0; k < 2; k++) begin
         if (in_valid[k] && mq.size() < DEPTH) mq.push_back(wake(slot_to_model(k)));
      end
      m_full = mq.size() > DEPTH - 2;
   endfunction

   task automatic compare_model();
      int s;
      bit ev;
      s  = first_ready();
      ev = !flush && (s >= 0);
      check_val("out_valid", 192'(out_valid), 192'(ev));
      if (ev) check_val("out_entry", 192'(out_entry), 192'(to_entry(mq[s])));
      check_val("full", 192'(full), 192'(m_full));
   endtask

   task automatic clear_inputs();
      flush     = 1'b0;
      out_ready = 1'b0;
      cdb_valid = 1'b0;
      cdb_tag   = '0;
      cdb_data  = '0;
      for (int k = 0; k < 2; k++) begin
         in_valid[k]      = 1'b0;
         in_address[k]    = '0;
         in_immediate[k]  = '0;
         in_instr_name[k] = I_NOP;
         in_regs[k]       = '0;
         for (int j = 0; j < 2; j++) begin
            in_src_val[k][j] = '0;
            in_src_rdy[k][j] = 1'b0;
         end
      end
   endtask

   // One cycle: compare outputs, step model, cross the edge, idle the inputs.
   task automatic tick();
      #1;
      compare_model();
      model_step();
      @(posedge clk);
      @(negedge clk);
      clear_inputs();
      #1;
   endtask

   task automatic set_slot(input int k, input logic [31:0] addr,
                           input logic [5:0] t1, input logic r1, input logic [31:0] v1,
                           input logic [5:0] t2, input logic r2, input logic [31:0] v2);
      in_valid[k]      = 1'b1;
      in_address[k]    = addr;
      in_immediate[k]  = addr ^ 32'h0000_F0F0;
      in_instr_name[k] = I_ADD;
      in_regs[k]       = '{src1: t1, src2: t2, dest: 6'(addr[7:2])};
      in_src_val[k][0] = v1;
      in_src_rdy[k][0] = r1;
      in_src_val[k][1] = v2;
      in_src_rdy[k][1] = r2;
   endtask

   initial begin
      int room;
      int exp_disp;
      clear_inputs();
      reset  = 1'b0;
      m_full = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check_val("reset_out_valid", 192'(out_valid), 192'(1'b0));
      check_val("reset_full", 192'(full), 192'(1'b0));
      reset = 1'b1;

      // Single ready insert becomes visible one cycle later.
      set_slot(0, 32'h100, 6'd1, 1'b1, 32'h11, 6'd2, 1'b1, 32'h22);
      tick();
      check_val("single_valid", 192'(out_valid), 192'(1'b1));
      check_val("single_addr", 192'(out_entry.address), 192'(32'h100));
      check_val("single_full", 192'(full), 192'(1'b0));
      out_ready = 1'b1;
      tick();
      check_val("single_drained", 192'(out_valid), 192'(1'b0));

      // Operand wakeup through the CDB.
      set_slot(0, 32'h200, 6'd5, 1'b0, 32'h0, 6'd3, 1'b1, 32'h7);
      tick();
      for (int i = 0; i < 3; i++) begin
         check_val("wait_no_valid", 192'(out_valid), 192'(1'b0));
         tick();
      end
      cdb_valid = 1'b1; cdb_tag = 6'd5; cdb_data = 32'hDEAD;
      tick();
      check_val("wake_valid", 192'(out_valid), 192'(1'b1));
      check_val("wake_src1", 192'(out_entry.src1_val), 192'(32'hDEAD));
      out_ready = 1'b1;
      tick();

      // CDB capture in the insert cycle.
      set_slot(0, 32'h300, 6'd1, 1'b1, 32'h1, 6'd9, 1'b0, 32'h0);
      cdb_valid = 1'b1; cdb_tag = 6'd9; cdb_data = 32'h42;
      tick();
      check_val("capture_valid", 192'(out_valid), 192'(1'b1));
      check_val("capture_src2", 192'(out_entry.src2_val), 192'(32'h42));
      out_ready = 1'b1;
      tick();

      // Oldest-first dispatch with compaction.
      set_slot(0, 32'h400, 6'd1, 1'b1, 32'hA1, 6'd2, 1'b1, 32'hA2);
      set_slot(1, 32'h404, 6'd1, 1'b1, 32'hB1, 6'd2, 1'b1, 32'hB2);
      tick();
      check_val("order_a", 192'(out_entry.address), 192'(32'h400));
      set_slot(0, 32'h408, 6'd1, 1'b1, 32'hC1, 6'd2, 1'b1, 32'hC2);
      out_ready = 1'b1;
      tick();
      check_val("order_b", 192'(out_entry.address), 192'(32'h404));
      out_ready = 1'b1;
      tick();
      check_val("order_c", 192'(out_entry.address), 192'(32'h408));
      out_ready = 1'b1;
      tick();
      check_val("order_empty", 192'(out_valid), 192'(1'b0));

      // Fill to full, then dispatch and insert together at count 7.
      for (int n = 0; n < 3; n++) begin
         set_slot(0, 32'h500 + 32'(8 * n), 6'd1, 1'b1, 32'h1, 6'd2, 1'b1, 32'h2);
         set_slot(1, 32'h504 + 32'(8 * n), 6'd1, 1'b1, 32'h1, 6'd2, 1'b1, 32'h2);
         tick();
      end
      check_val("fill_six_not_full", 192'(full), 192'(1'b0));
      set_slot(0, 32'h518, 6'd1, 1'b1, 32'h1, 6'd2, 1'b1, 32'h2);
      tick();
      check_val("fill_seven_full", 192'(full), 192'(1'b1));
      set_slot(0, 32'h51C, 6'd1, 1'b1, 32'h1, 6'd2, 1'b1, 32'h2);
      out_ready = 1'b1;
      tick();
      check_val("swap_still_full", 192'(full), 192'(1'b1));
      check_val("swap_oldest", 192'(out_entry.address), 192'(32'h504));

      // Drain to 5 entries, then flush while an insert is presented.
      out_ready = 1'b1;
      tick();
      out_ready = 1'b1;
      tick();
      check_val("five_not_full", 192'(full), 192'(1'b0));
      flush = 1'b1;
      set_slot(0, 32'h600, 6'd1, 1'b1, 32'h1, 6'd2, 1'b1, 32'h2);
      #1;
      check_val("flush_forces_invalid", 192'(out_valid), 192'(1'b0));
      tick();
      check_val("flush_empty", 192'(out_valid), 192'(1'b0));
      check_val("flush_full", 192'(full), 192'(1'b0));

      // Randomized traffic checked every cycle against the model.
      for (int c = 0; c < 3000; c++) begin
         flush     = ($urandom_range(0, 49) == 0);
         out_ready = ($urandom_range(0, 2) != 0);
         cdb_valid = $urandom_range(0, 1) == 1;
         cdb_tag   = 6'($urandom_range(0, 7));
         cdb_data  = $urandom;
         for (int k = 0; k < 2; k++) begin
            set_slot(k, $urandom, 6'($urandom_range(0, 7)), $urandom_range(0, 3) != 0, $urandom,
                     6'($urandom_range(0, 7)), $urandom_range(0, 3) != 0, $urandom);
            in_valid[k]      = $urandom_range(0, 2) != 0;
            in_instr_name[k] = instr_name_e'(4'($urandom_range(0, 10)));
            in_regs[k].dest  = 6'($urandom);
         end
         if (!flush) begin
            exp_disp = (first_ready() >= 0 && out_ready) ? 1 : 0;
            room     = DEPTH - mq.size() + exp_disp;
            if (in_valid[1] && (int'(in_valid[0]) + 1 > room)) in_valid[1] = 1'b0;
            if (in_valid[0] && room < 1) in_valid[0] = 1'b0;
         end
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
